// File: rtl/multi_edge_detector.sv
// Multi-channel synchronising edge detector with mode-qualified events, sticky flags and a saturating event counter.
// Optional per-channel debounce filter is enabled by defining EDGE_DEBOUNCE_EN.
`timescale 1ns/1ps

module multi_edge_detector #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [2*WIDTH-1:0]   mode_i,
    input  logic [WIDTH-1:0]     clr_i,
    input  logic                 cnt_clr_i,
    output logic [WIDTH-1:0]     rising_edge_o,
    output logic [WIDTH-1:0]     falling_edge_o,
    output logic [WIDTH-1:0]     event_o,
    output logic [WIDTH-1:0]     sticky_o,
    output logic                 irq_o,
    output logic [CNT_W-1:0]     evt_cnt_o
);

    // The sum is wide enough for a full counter plus a 32-channel popcount.
    localparam int SUM_W = CNT_W + 6;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || DEB_CYCLES < 1 || CNT_W < 1) begin : g_bad_params
        $error("multi_edge_detector: illegal parameter value");
    end

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise_c;
    logic [WIDTH-1:0] fall_c;
    logic [WIDTH-1:0] mode_rise;
    logic [WIDTH-1:0] mode_fall;
    logic [5:0]       pop;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= a_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES) + 1;

    logic [DEB_W-1:0] deb_cnt [WIDTH];

    // filt only follows the synchroniser once it has disagreed for DEB_CYCLES consecutive clocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt <= '0;
            for (int c = 0; c < WIDTH; c++) deb_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < WIDTH; c++) begin
                if (sync_out[c] == filt[c]) begin
                    deb_cnt[c] <= '0;
                end else if (deb_cnt[c] == DEB_W'(DEB_CYCLES - 1)) begin
                    filt[c]    <= sync_out[c];
                    deb_cnt[c] <= '0;
                end else begin
                    deb_cnt[c] <= deb_cnt[c] + 1'b1;
                end
            end
        end
    end
`else
    assign filt = sync_out;
`endif

    assign rise_c = filt & ~prev;
    assign fall_c = ~filt & prev;

    always_comb begin
        mode_rise = '0;
        mode_fall = '0;
        pop       = '0;
        for (int c = 0; c < WIDTH; c++) begin
            mode_rise[c] = mode_i[2*c];
            mode_fall[c] = mode_i[2*c+1];
            pop          = pop + 6'(event_o[c]);
        end
    end

    // A counter clear discards the old total but still counts this cycle's events.
    always_comb begin
        if (cnt_clr_i) sum = SUM_W'(pop);
        else           sum = SUM_W'(evt_cnt_o) + SUM_W'(pop);
        cnt_next = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev           <= '0;
            rising_edge_o  <= '0;
            falling_edge_o <= '0;
            event_o        <= '0;
            sticky_o       <= '0;
            evt_cnt_o      <= '0;
        end else begin
            prev           <= filt;
            rising_edge_o  <= rise_c;
            falling_edge_o <= fall_c;
            event_o        <= (rise_c & mode_rise) | (fall_c & mode_fall);
            sticky_o       <= (sticky_o & ~clr_i) | event_o;
            evt_cnt_o      <= cnt_next;
        end
    end

    assign irq_o = |sticky_o;

endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of independent input channels, legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth per channel, minimum 2.
REQ-003 SHALL have parameter DEB_CYCLES, default 4: debounce stability window in clocks, minimum 1.
REQ-004 SHALL have parameter CNT_W, default 8: width of the event counter.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all flops clocked on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port a_i, input, WIDTH bits: asynchronous channel inputs.
REQ-008 SHALL have port mode_i, input, 2*WIDTH bits: per-channel mode at bits [2c+1:2c]; 00 off, 01 rising, 10 falling, 11 both.
REQ-009 SHALL have port clr_i, input, WIDTH bits: write-1-to-clear for the sticky flags.
REQ-010 SHALL have port cnt_clr_i, input, 1 bit: synchronous clear of the event counter.
REQ-011 SHALL have ports rising_edge_o and falling_edge_o, outputs, WIDTH bits each: raw single-cycle edge pulses, independent of mode.
REQ-012 SHALL have port event_o, output, WIDTH bits: mode-qualified single-cycle pulses.
REQ-013 SHALL have port sticky_o, output, WIDTH bits: latched event flags.
REQ-014 SHALL have port irq_o, output, 1 bit: OR-reduction of sticky_o.
REQ-015 SHALL have port evt_cnt_o, output, CNT_W bits: saturating count of all events.

Function
REQ-016 SHALL pass each a_i bit through a SYNC_STAGES-deep flop chain before any other use.
REQ-017 SHALL hold a filtered state per channel, plus a prev register holding the filtered state from the previous clock.
REQ-018 SHALL generate rising_edge_o[c] = filt & ~prev and falling_edge_o[c] = ~filt & prev as registered outputs, each high for exactly one cycle per transition.
REQ-019 SHALL register event_o[c] in the same cycle as the raw pulse, qualified by mode_i[c] as sampled on that edge.
REQ-020 SHALL make a mode_i change affect only edges whose pulse is registered after the change; no retroactive or pending events.
REQ-021 SHALL set sticky_o[c] one clock after event_o[c] is high; clr_i[c] clears it on the next edge; a simultaneous set and clear leaves the flag set.
REQ-022 SHALL add popcount(event_o) to evt_cnt_o each clock, saturating at 2^CNT_W-1 with no wrap.
REQ-023 SHALL, when cnt_clr_i and events coincide, load evt_cnt_o with that cycle's popcount.
REQ-024 SHALL give irq_o combinationally from sticky_o.
REQ-025 SHALL give a_i stable from edge k (no debounce) a raw pulse visible after edge k+SYNC_STAGES.

Reset
REQ-026 SHALL asynchronously clear all synchroniser, filter, prev, counter, pulse, sticky and evt_cnt flops to 0 while reset_n is low.
REQ-027 SHALL, if a_i is high at reset release, produce a rising edge after normal latency; no falling edge results.
REQ-028 SHALL let reset mid-debounce discard the partial count; no pulse is emitted for the aborted transition.

Configuration
REQ-029 SHALL use macro EDGE_DEBOUNCE_EN: when defined, each channel has a debounce counter of width clog2(DEB_CYCLES)+1.
REQ-030 SHALL, with EDGE_DEBOUNCE_EN defined, reset the counter to 0 whenever the sync output equals filt, increment it otherwise, and update filt when sync differs and the counter equals DEB_CYCLES-1; pulse latency becomes SYNC_STAGES+DEB_CYCLES edges.
REQ-031 SHALL, with EDGE_DEBOUNCE_EN undefined, make filt equal the sync output directly; DEB_CYCLES is ignored and no counter logic is synthesised.

Verification
REQ-032 SHALL cover: a_i[0] 0->1 held, SYNC_STAGES=2, mode 01, no debounce -> rising_edge_o[0] and event_o[0] high for 1 cycle after edge k+2, sticky_o[0]=1 and irq_o=1 next cycle, evt_cnt_o=1.
REQ-033 SHALL cover: mode 10 on ch3, a_i[3] 0->1->0 -> rising_edge_o[3] pulses with no event_o[3]; falling pulse with event_o[3]; evt_cnt_o=1.
REQ-034 SHALL cover: EDGE_DEBOUNCE_EN, DEB_CYCLES=4, a 3-cycle glitch -> no pulses; 4-cycle stable high -> one rising pulse at edge k+6.
REQ-035 SHALL cover: all 8 channels rising together with mode 11, evt_cnt_o at 250 -> evt_cnt_o=255 saturated; with cnt_clr_i asserted in the same cycle -> evt_cnt_o=8.
REQ-036 SHALL cover: clr_i[2] asserted in the same cycle event_o[2] sets -> sticky_o[2] stays 1; clr_i[2] alone next cycle -> 0, irq_o=0.
REQ-037 SHALL cover: reset_n asserted mid-debounce with a_i=1 -> all outputs 0 immediately; after release, one rising pulse at full latency.
